// File: rtl/vga_timing_pkg.sv
//==============================================================================
// Module : vga_timing_pkg
// Brief  : Default VGA 640x480 raster constants and the sync bundle type.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // Syncs are active-low, so the idle bundle has hs/vs high and de low.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

  function automatic logic in_range(input logic [9:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_sync_delay.sv
//==============================================================================
// Module : sync_delay
// Brief  : Clock-enable gated shift register with reset value; wire at DEPTH=0.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module sync_delay #(
  parameter int  DEPTH     = 1,
  parameter type T         = vga_timing_pkg::sync_t,
  parameter T    RESET_VAL = T'('0)
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  T     din,
  output T     dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = clk ^ reset ^ ce;
      assign dout     = din;
    end else begin : g_shift
      T r_stage [DEPTH];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
        end else if (ce) begin
          r_stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign dout = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//==============================================================================
// Module : vga_timing_gen
// Brief  : Raster counters, delayed hsync/vsync/vde, frame pulse/count, blink.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_BACK     = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_BACK     = vga_timing_pkg::V_BACK,
  parameter int PIPE_DELAY = 1,
  parameter int BLINK_LOG2 = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hsync,
  output logic       vsync,
  output logic       vde,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       blink
);

  import vga_timing_pkg::*;

  localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
  localparam logic [9:0] c_hs_start = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_hs_end   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] c_vs_start = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_vs_end   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] c_h_vis    = 10'(H_VISIBLE);
  localparam logic [9:0] c_v_vis    = 10'(V_VISIBLE);
  localparam logic [2:0] c_blink    = 3'(BLINK_LOG2);

  generate
    if (c_h_total > 1024 || c_v_total > 1024 || PIPE_DELAY < 0 || PIPE_DELAY > 4 ||
        BLINK_LOG2 < 0 || BLINK_LOG2 > 7) begin : g_bad_params
      $error("vga_timing_gen: totals must fit 10 bits, PIPE_DELAY 0..4, BLINK_LOG2 0..7");
    end
  endgenerate

  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic       r_frame_start;
  logic [7:0] r_frame_count;
  logic       w_h_last;
  logic       w_v_last;
  sync_t      w_raw;
  sync_t      w_dly;

  assign w_h_last = (r_hc == c_h_last);
  assign w_v_last = (r_vc == c_v_last);

  // frame_start is cleared on every edge, so it only survives one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_start <= 1'b0;
      if (pix_ce) begin
        if (w_h_last) begin
          r_hc <= '0;
          if (w_v_last) begin
            r_vc          <= '0;
            r_frame_start <= 1'b1;
            r_frame_count <= r_frame_count + 8'd1;
          end else begin
            r_vc <= r_vc + 10'd1;
          end
        end else begin
          r_hc <= r_hc + 10'd1;
        end
      end
    end
  end

  always_comb begin
    w_raw    = SYNC_IDLE;
    w_raw.hs = ~in_range(r_hc, c_hs_start, c_hs_end);
    w_raw.vs = ~in_range(r_vc, c_vs_start, c_vs_end);
    w_raw.de = (r_hc < c_h_vis) && (r_vc < c_v_vis);
  end

  sync_delay #(
    .DEPTH     (PIPE_DELAY),
    .T         (sync_t),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .ce    (pix_ce),
    .din   (w_raw),
    .dout  (w_dly)
  );

  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign hsync       = w_dly.hs;
  assign vsync       = w_dly.vs;
  assign vde         = w_dly.de;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;
  assign blink       = r_frame_count[c_blink];

endmodule

`default_nettype wire
